// File: rtl/quic_varint_stream_dec.sv
`timescale 1ns/1ps
// Streaming QUIC variable-length integer decoder: byte stream in, one registered
// result (value, encoded length, error code) per varint out, valid/ready on both sides.
//
// state | meaning
// IDLE  | next accepted byte is a varint prefix byte
// ACCUM | continuation bytes of a multi-byte varint are being collected
module quic_varint_stream_dec #(
   parameter int VALUE_W   = 62,
   parameter int MAX_LEN   = 8,
   parameter int CHECK_MIN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [VALUE_W-1:0] out_value,
   output logic [3:0]         out_len,
   output logic [1:0]         out_err,
   input  logic               out_ready,
   output logic               busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state, state_n;
   logic [61:0]        acc, acc_n;
   logic [2:0]         rem, rem_n;
   logic [3:0]         len, len_n;
   logic               accept;
   logic               done;
   logic [61:0]        acc_hi;
   logic               non_min;
   logic [VALUE_W-1:0] val_n;
   logic [1:0]         err_n;

   // A stalled result blocks the input so no completion can ever be lost.
   assign in_ready = rst && (!out_valid || out_ready) && !abort;
   assign accept   = in_valid && in_ready;
   assign busy     = (state == ACCUM);

   always_comb begin
      state_n = state;
      acc_n   = acc;
      rem_n   = rem;
      len_n   = len;
      done    = 1'b0;
      if (abort) begin
         state_n = IDLE;
         acc_n   = '0;
         rem_n   = '0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc_n = {56'd0, in_data[5:0]};
            case (in_data[7:6])
               2'd0:    len_n = 4'd1;
               2'd1:    len_n = 4'd2;
               2'd2:    len_n = 4'd4;
               default: len_n = 4'd8;
            endcase
            rem_n = 3'(len_n - 4'd1);
            if (len_n == 4'd1) done = 1'b1;
            else               state_n = ACCUM;
         end else begin
            acc_n = {acc[53:0], in_data};
            rem_n = rem - 3'd1;
            if (rem == 3'd1) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
      end
   end

   // Result classification on the completed accumulator; first matching error wins.
   always_comb begin
      acc_hi  = acc_n >> VALUE_W;
      non_min = (len_n == 4'd2 && acc_n < 62'd64) ||
                (len_n == 4'd4 && acc_n < 62'd16384) ||
                (len_n == 4'd8 && acc_n < 62'd1073741824);
      val_n   = acc_n[VALUE_W-1:0];
      err_n   = 2'd0;
      if (len_n > 4'(MAX_LEN)) begin
         err_n = 2'd1;
         val_n = '0;
      end else if (acc_hi != '0) begin
         err_n = 2'd3;
      end else if (CHECK_MIN != 0 && non_min) begin
         err_n = 2'd2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         rem       <= '0;
         len       <= '0;
         out_valid <= 1'b0;
         out_value <= '0;
         out_len   <= '0;
         out_err   <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         rem   <= rem_n;
         len   <= len_n;
         if (done) begin
            out_valid <= 1'b1;
            out_value <= val_n;
            out_len   <= len_n;
            out_err   <= err_n;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quic_varint_stream_dec.sv
`timescale 1ns/1ps
// Scoreboard bench: two decoder configurations share one byte stream; expected
// results come from an arithmetic varint model and are checked by a separate monitor.
module tb_quic_varint_stream_dec;

   typedef struct packed {
      logic [63:0] val;
      logic [3:0]  len;
      logic [1:0]  err;
   } exp_t;
   typedef logic [7:0] bytes_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        out_ready = 1'b1;
   int          or_mode = 0;

   logic        in_ready1, out_valid1, busy1;
   logic [61:0] out_value1;
   logic [3:0]  out_len1;
   logic [1:0]  out_err1;
   logic        in_ready2, out_valid2, busy2;
   logic [15:0] out_value2;
   logic [3:0]  out_len2;
   logic [1:0]  out_err2;

   exp_t        q1[$], q2[$];
   exp_t        e1, e2;
   int          n_checks = 0;
   int          n_errors = 0;
   int          stall_cnt = 0;
   bit          st1 = 0, st2 = 0;
   logic [61:0] sv1;
   logic [15:0] sv2;

   quic_varint_stream_dec #(.VALUE_W(62), .MAX_LEN(8), .CHECK_MIN(1)) dut1 (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_value(out_value1),
      .out_len(out_len1), .out_err(out_err1), .out_ready(out_ready), .busy(busy1));

   quic_varint_stream_dec #(.VALUE_W(16), .MAX_LEN(4), .CHECK_MIN(0)) dut2 (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .out_valid(out_valid2), .out_value(out_value2),
      .out_len(out_len2), .out_err(out_err2), .out_ready(out_ready), .busy(busy2));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 99) < 65);
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input bytes_t b, input int vw, input int ml, input int cm);
      exp_t            r;
      logic [7:0]      p;
      longint unsigned v, lim, minv;
      int              n;
      p    = b[0];
      n    = 1 << p[7:6];
      v    = 64'(p & 8'h3F);
      for (int i = 1; i < n; i++) v = v * 256 + 64'(b[i]);
      minv = (n == 1) ? 0 : (n == 2) ? 64 : (n == 4) ? 16384 : 64'd1 << 30;
      lim  = 64'd1 << vw;
      r.len = 4'(n);
      if (n > ml)                    begin r.err = 2'd1; r.val = 64'd0;   end
      else if (v >= lim)             begin r.err = 2'd3; r.val = v % lim; end
      else if (cm != 0 && v < minv)  begin r.err = 2'd2; r.val = v;       end
      else                           begin r.err = 2'd0; r.val = v;       end
      return r;
   endfunction

   task automatic push_exp(input bytes_t b);
      q1.push_back(model(b, 62, 8, 1));
      q2.push_back(model(b, 16, 4, 0));
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bit got = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!got) begin
         @(negedge clk);
         if (in_ready1) got = 1;
         @(posedge clk);
         #1;
         t++;
         if (!got && t > 1000) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            got = 1;
         end
      end
   endtask

   task automatic send_bytes(input bytes_t b);
      foreach (b[i]) send_byte(b[i]);
   endtask

   task automatic issue(input bytes_t b);
      push_exp(b);
      send_bytes(b);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      int prev = or_mode;
      or_mode = 0;
      while ((q1.size() != 0 || q2.size() != 0) && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      @(posedge clk);
      #1;
      check("drain_q1", 64'(q1.size()), 64'd0);
      check("drain_q2", 64'(q2.size()), 64'd0);
      or_mode = prev;
   endtask

   always @(negedge clk) begin
      if (rst && st1 && out_valid1) check("dut1_stable", 64'(out_value1), 64'(sv1));
      if (rst && st2 && out_valid2) check("dut2_stable", 64'(out_value2), 64'(sv2));
      st1 = rst && out_valid1 && !out_ready;
      st2 = rst && out_valid2 && !out_ready;
      sv1 = out_value1;
      sv2 = out_value2;
      if (in_valid && !in_ready1) stall_cnt++;
      if (rst && out_valid1 && out_ready) begin
         if (q1.size() == 0) check("dut1_unexpected", 64'd1, 64'd0);
         else begin
            e1 = q1.pop_front();
            check("dut1_value", 64'(out_value1), e1.val);
            check("dut1_len", 64'(out_len1), 64'(e1.len));
            check("dut1_err", 64'(out_err1), 64'(e1.err));
         end
      end
      if (rst && out_valid2 && out_ready) begin
         if (q2.size() == 0) check("dut2_unexpected", 64'd1, 64'd0);
         else begin
            e2 = q2.pop_front();
            check("dut2_value", 64'(out_value2), e2.val);
            check("dut2_len", 64'(out_len2), 64'(e2.len));
            check("dut2_err", 64'(out_err2), 64'(e2.err));
         end
      end
   end

   initial begin
      bytes_t b;
      int     n, bits, sel;
      logic [63:0] r, mask, v, minv;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready1), 64'd0);
      check("rst_out_valid", 64'(out_valid1), 64'd0);
      check("rst_out_value", 64'(out_value1), 64'd0);
      check("rst_out_len", 64'(out_len1), 64'd0);
      check("rst_out_err", 64'(out_err1), 64'd0);
      check("rst_busy", 64'(busy1), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready1), 64'd1);
      @(posedge clk); #1;

      // back-to-back stream of all four lengths at full rate
      or_mode = 0;
      stall_cnt = 0;
      b = '{8'h25}; issue(b);
      b = '{8'h7B, 8'hBD}; issue(b);
      b = '{8'h9D, 8'h7F, 8'h3E, 8'h7D}; issue(b);
      b = '{8'hC2, 8'h19, 8'h7C, 8'h5E, 8'hFF, 8'h14, 8'hE8, 8'h8C}; issue(b);
      check("full_rate_stalls", 64'(stall_cnt), 64'd0);
      idle(2);
      wait_drain();

      // non-minimal, over-length then realignment, value overflow
      b = '{8'h40, 8'h25}; issue(b);
      b = '{8'hC2, 8'h19, 8'h7C, 8'h5E, 8'hFF, 8'h14, 8'hE8, 8'h8C}; issue(b);
      b = '{8'h25}; issue(b);
      b = '{8'h9D, 8'h7F, 8'h3E, 8'h7D}; issue(b);
      idle(2);
      wait_drain();

      // output stall holds the next byte
      or_mode = 1;
      b = '{8'h25}; push_exp(b); send_bytes(b);
      b = '{8'h26}; push_exp(b);
      in_valid = 1'b1;
      in_data  = 8'h26;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid1), 64'd1);
      check("stall_out_value", 64'(out_value1), 64'd37);
      check("stall_in_ready", 64'(in_ready1), 64'd0);
      @(posedge clk); #1;
      or_mode = 0;
      send_byte(8'h26);
      or_mode = 1;
      in_valid = 1'b0;
      @(negedge clk);
      check("stall_next_valid", 64'(out_valid1), 64'd1);
      check("stall_next_value", 64'(out_value1), 64'd38);
      @(posedge clk); #1;
      or_mode = 0;
      wait_drain();

      // abort mid-varint
      b = '{8'h7B}; send_bytes(b);
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_busy_before", 64'(busy1), 64'd1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk);
      check("abort_in_ready", 64'(in_ready1), 64'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy_after", 64'(busy1), 64'd0);
      @(posedge clk); #1;
      b = '{8'h25}; issue(b);
      idle(2);
      wait_drain();

      // reset mid-varint
      b = '{8'h7B}; send_bytes(b);
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_busy_before", 64'(busy1), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid_busy", 64'(busy1), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready1), 64'd0);
      check("rst_mid_out_value", 64'(out_value1), 64'd0);
      check("rst_mid_out_len", 64'(out_len1), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      b = '{8'h25}; issue(b);
      idle(2);
      wait_drain();

      // randomized stream with random backpressure and input gaps
      or_mode = 2;
      for (int k = 0; k < 400; k++) begin
         n    = 1 << $urandom_range(0, 3);
         bits = 8 * n - 2;
         mask = (64'd1 << bits) - 64'd1;
         minv = (n == 1) ? 64'd0 : (n == 2) ? 64'd64 : (n == 4) ? 64'd16384 : 64'd1 << 30;
         r    = {$urandom(), $urandom()};
         v    = r & mask;
         sel  = $urandom_range(0, 7);
         case (sel)
            0: v = v >> $urandom_range(0, bits);
            1: v = (minv != 0) ? minv - 64'd1 : 64'd0;
            2: v = minv;
            3: v = mask;
            4: v = 64'hFFFF & mask;
            5: v = 64'h10000 & mask;
            default: ;
         endcase
         b = {};
         for (int i = 0; i < n; i++) b.push_back(8'(v >> (8 * (n - 1 - i))));
         b[0] = (b[0] & 8'h3F) | (8'($clog2(n)) << 6);
         issue(b);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      idle(2);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
